pipeline_stall_ctrl: RTL and testbench

- Consumer side of the hazard handshake in the 5-stage RISC-V pipeline.
- Takes the stall request from the hazard detector, the EX-stage flush request and the ID-stage halting ecall. Drives PC write enable, the IF/ID register with its valid bit, and bubble insertion into ID/EX.
- Sequences a clean halt by draining the back end, and keeps saturating stall/flush event counters.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 13 +
 rtl/pipeline_stall_ctrl_if.sv | 32 +++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 20 ++
 rtl/pipeline_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline constants and the stall controller state encoding.
package pipeline_pkg;

    localparam logic [31:0]  NOP_INST        = 32'h00000013;
    localparam int unsigned  ECALL_HALT_CODE = 10;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard handshake between the front end and the stall controller.
interface pipeline_stall_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic              is_stall;
    logic              flush;
    logic              ecall_halt;
    logic [XLEN-1:0]   if_pc;
    logic [XLEN-1:0]   if_inst;
    logic              pc_write;
    logic [XLEN-1:0]   if_id_pc;
    logic [XLEN-1:0]   if_id_inst;
    logic              if_id_valid;
    logic              id_ex_bubble;
    logic              halt_pending;
    logic              is_halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output is_stall, flush, ecall_halt, if_pc, if_inst,
        input  pc_write, if_id_pc, if_id_inst, if_id_valid, id_ex_bubble,
               halt_pending, is_halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  is_stall, flush, ecall_halt, if_pc, if_inst,
        output pc_write, if_id_pc, if_id_inst, if_id_valid, id_ex_bubble,
               halt_pending, is_halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter for pipeline event statistics.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Consumer of the hazard handshake: PC/IF-ID control, halt drain, event counters.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_stall_ctrl_if.slave  bus
);

    localparam int unsigned DW = (DRAIN_CYCLES + 1 > 2) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

    ctrl_state_e      state;
    logic [DW-1:0]    drain_cnt;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_inst;
    logic             id_valid;
    logic             halted;
    logic             running;
    logic             pc_write;
    logic             bubble;
    logic             stall_inc;
    logic             flush_inc;

    assign running   = (state == RUN);
    assign stall_inc = running && !bus.flush && bus.is_stall;
    assign flush_inc = running && bus.flush;

    // Same-cycle PC enable and ID/EX bubble; priority flush > stall > ecall.
    always_comb begin
        pc_write = 1'b0;
        bubble   = 1'b1;
        if (running) begin
            if (bus.flush) begin
                pc_write = 1'b1;
                bubble   = 1'b1;
            end else if (bus.is_stall) begin
                pc_write = 1'b0;
                bubble   = 1'b1;
            end else if (bus.ecall_halt) begin
                pc_write = 1'b0;
                bubble   = 1'b0;
            end else begin
                pc_write = 1'b1;
                bubble   = 1'b0;
            end
        end
    end

    // State sequencing and the IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            id_pc     <= '0;
            id_inst   <= XLEN'(NOP_INST);
            id_valid  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            halted <= (state == HALTED);
            unique case (state)
                RUN: begin
                    if (bus.flush) begin
                        id_inst  <= XLEN'(NOP_INST);
                        id_valid <= 1'b0;
                    end else if (bus.is_stall) begin
                        id_valid <= id_valid;
                    end else if (bus.ecall_halt) begin
                        id_inst   <= XLEN'(NOP_INST);
                        id_valid  <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                        state     <= DRAIN;
                    end else begin
                        id_pc    <= bus.if_pc;
                        id_inst  <= bus.if_inst;
                        id_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    id_inst  <= XLEN'(NOP_INST);
                    id_valid <= 1'b0;
                    if (drain_cnt == '0) begin
                        state <= HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                HALTED: begin
                    id_inst  <= XLEN'(NOP_INST);
                    id_valid <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (bus.flush_cnt)
    );

    assign bus.pc_write     = pc_write;
    assign bus.id_ex_bubble = bubble;
    assign bus.if_id_pc     = id_pc;
    assign bus.if_id_inst   = id_inst;
    assign bus.if_id_valid  = id_valid;
    assign bus.halt_pending = (state == DRAIN);
    assign bus.is_halted    = halted;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed plus random checks of pipeline_stall_ctrl against an edge-counting model.
module tb_pipeline_stall_ctrl;
    import pipeline_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          DC    = 3;
    localparam int          SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(DC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: age = edges since the halting ecall was accepted (-1 = none).
    int          age;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    int          m_sc;
    int          m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit fl, input bit ec,
                        input logic [31:0] pc, input logic [31:0] inst);
        logic e_pw;
        logic e_bub;
        reset          = r;
        bus.is_stall   = st;
        bus.flush      = fl;
        bus.ecall_halt = ec;
        bus.if_pc      = pc;
        bus.if_inst    = inst;
        #4;
        if (age >= 0)  begin e_pw = 1'b0; e_bub = 1'b1; end
        else if (fl)   begin e_pw = 1'b1; e_bub = 1'b1; end
        else if (st)   begin e_pw = 1'b0; e_bub = 1'b1; end
        else if (ec)   begin e_pw = 1'b0; e_bub = 1'b0; end
        else           begin e_pw = 1'b1; e_bub = 1'b0; end
        chk("pc_write", 32'(bus.pc_write), 32'(e_pw));
        chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));
        @(posedge clk);
        if (r) begin
            age = -1; m_valid = 1'b0; m_inst = NOP_INST; m_pc = 32'h0; m_sc = 0; m_fc = 0;
        end else if (age >= 0) begin
            age++;
        end else if (fl) begin
            m_valid = 1'b0; m_inst = NOP_INST;
            if (m_fc < SAT) m_fc++;
        end else if (st) begin
            if (m_sc < SAT) m_sc++;
        end else if (ec) begin
            m_valid = 1'b0; m_inst = NOP_INST; age = 0;
        end else begin
            m_valid = 1'b1; m_pc = pc; m_inst = inst;
        end
        #1;
        chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
        chk("if_id_inst", bus.if_id_inst, m_inst);
        if (m_valid || r) chk("if_id_pc", bus.if_id_pc, m_pc);
        chk("halt_pending", 32'(bus.halt_pending), 32'((age >= 0) && (age <= DC - 1)));
        chk("is_halted", 32'(bus.is_halted), 32'(age >= DC + 1));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_sc));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_fc));
    endtask

    initial begin
        age = -1; m_valid = 1'b0; m_inst = NOP_INST; m_pc = 32'h0; m_sc = 0; m_fc = 0;
        reset = 1'b1;
        bus.is_stall = 1'b0; bus.flush = 1'b0; bus.ecall_halt = 1'b0;
        bus.if_pc = 32'h0; bus.if_inst = 32'h0;
        @(posedge clk); #1;

        // Reset state
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        chk("reset_inst_nop", bus.if_id_inst, 32'h00000013);
        chk("reset_valid", 32'(bus.if_id_valid), 32'd0);

        // Load-use stall holds IF/ID for two cycles
        step(0, 0, 0, 0, 32'h0000000C, 32'h00100093);
        step(0, 1, 0, 0, 32'h00000010, 32'h00A00093);
        step(0, 1, 0, 0, 32'h00000010, 32'h00A00093);
        chk("stall_cnt_two", 32'(bus.stall_cnt), 32'd2);
        chk("stall_hold_pc", bus.if_id_pc, 32'h0000000C);
        chk("stall_hold_inst", bus.if_id_inst, 32'h00100093);

        // Flush beats simultaneous stall and ecall
        step(0, 1, 1, 1, 32'h00000014, 32'h00000073);
        chk("flush_cnt_one", 32'(bus.flush_cnt), 32'd1);
        chk("flush_stall_same", 32'(bus.stall_cnt), 32'd2);
        chk("flush_no_drain", 32'(bus.halt_pending), 32'd0);
        step(0, 0, 0, 0, 32'h00000020, 32'h00200113);

        // Ecall under stall, then a flush in the middle of DRAIN
        step(0, 1, 0, 1, 32'h00000024, 32'h00000073);
        chk("ecall_stalled_no_drain", 32'(bus.halt_pending), 32'd0);
        step(0, 0, 0, 1, 32'h00000024, 32'h00000073);
        chk("ecall_drain_entered", 32'(bus.halt_pending), 32'd1);
        step(0, 0, 1, 0, 32'h00000028, 32'h0);
        step(0, 1, 0, 0, 32'h0000002C, 32'h0);
        step(0, 0, 0, 0, 32'h00000030, 32'h0);
        chk("halted_not_yet", 32'(bus.is_halted), 32'd0);
        step(0, 0, 0, 0, 32'h00000034, 32'h0);
        chk("halted_fourth_edge", 32'(bus.is_halted), 32'd1);
        chk("drain_flush_ignored", 32'(bus.flush_cnt), 32'd1);
        step(0, 0, 1, 1, 32'h00000038, 32'h0);
        step(0, 1, 0, 0, 32'h0000003C, 32'h0);

        // Saturation of stall_cnt
        step(1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 32'h00000040, 32'h00000013);
        chk("stall_saturated", 32'(bus.stall_cnt), 32'(SAT));

        // Reset mid-DRAIN
        step(0, 0, 1, 0, 32'h00000044, 32'h0);
        step(0, 0, 0, 1, 32'h00000048, 32'h00000073);
        step(0, 0, 0, 0, 32'h0000004C, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        chk("rst_drain_pending", 32'(bus.halt_pending), 32'd0);
        chk("rst_drain_halted", 32'(bus.is_halted), 32'd0);
        chk("rst_drain_cnts", 32'({bus.stall_cnt, bus.flush_cnt}), 32'd0);
        step(0, 0, 0, 0, 32'h00000050, 32'h00300193);
        chk("rst_drain_running", 32'(bus.if_id_valid), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0),
                 $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
